cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/cpu_seq_decode.sv | 15 +
 rtl/cpu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcodes, FSM states, instruction fields.
package cpu_pkg;

    localparam int unsigned IR_W    = 9;
    localparam int unsigned OPC_HI  = 8;
    localparam int unsigned OPC_LO  = 7;
    localparam int unsigned REG_HI  = 6;
    localparam int unsigned REG_LO  = 5;
    localparam int unsigned ADDR_HI = 4;
    localparam int unsigned ADDR_LO = 0;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    // Register index of A3, the low half of the A4|A3 ALU writeback pair
    localparam logic [1:0] REG_PAIR_LO = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_LD_WB,
        S_STORE,
        S_EXEC,
        S_ALU_WB
    } state_t;

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational instruction decode: splits an instruction word into opcode, register and address.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  logic [8:0] ir,
    output logic [1:0] op,
    output logic [1:0] reg_sel,
    output logic [4:0] addr
);

    assign op      = ir[OPC_HI:OPC_LO];
    assign reg_sel = ir[REG_HI:REG_LO];
    assign addr    = ir[ADDR_HI:ADDR_LO];

endmodule

// File: rtl/cpu_sequencer.sv
// Load/store/ALU instruction sequencer with registered control strobes.
// Optional retired-instruction counter enabled by defining CPU_SEQ_PERF_EN.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  rf_rd_sel,
    output logic [1:0]  rf_wr_sel,
    output logic        rf_wr,
    output logic        rf_wr_src,
    output logic        wb_pair,
    output logic        alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        err,
`ifdef CPU_SEQ_PERF_EN
    output logic [15:0] retired_cnt,
`endif
    output logic        busy
);

    localparam logic [7:0] MEM_LAST = 8'(MEM_LAT - 1);
    localparam logic [7:0] TMO      = 8'(ALU_TIMEOUT);

    state_t     state, state_nxt;
    logic [8:0] ir, ir_nxt;
    logic [7:0] cnt, cnt_nxt;

    logic [8:0] dec_src;
    logic [1:0] dec_op, dec_reg;
    logic [4:0] dec_addr;

    logic [4:0] mem_addr_nxt;
    logic       mem_rd_nxt, mem_wr_nxt, rf_wr_nxt, rf_wr_src_nxt, wb_pair_nxt;
    logic       alu_op_nxt, alu_start_nxt, err_nxt;
    logic [1:0] rf_rd_sel_nxt, rf_wr_sel_nxt;

    assign instr_ready = (state == S_IDLE);
    assign busy        = ~instr_ready;

    // Outputs are registered on state entry, so IDLE decodes the incoming word and later states the IR
    assign dec_src = (state == S_IDLE) ? instr : ir;

    cpu_seq_decode u_decode (
        .ir      (dec_src),
        .op      (dec_op),
        .reg_sel (dec_reg),
        .addr    (dec_addr)
    );

    always_comb begin
        state_nxt     = state;
        ir_nxt        = ir;
        cnt_nxt       = '0;
        mem_addr_nxt  = mem_addr;
        mem_rd_nxt    = 1'b0;
        mem_wr_nxt    = 1'b0;
        rf_rd_sel_nxt = rf_rd_sel;
        rf_wr_sel_nxt = rf_wr_sel;
        rf_wr_nxt     = 1'b0;
        rf_wr_src_nxt = rf_wr_src;
        wb_pair_nxt   = 1'b0;
        alu_op_nxt    = alu_op;
        alu_start_nxt = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_nxt = instr;
                    case (dec_op)
                        OP_LOAD: begin
                            state_nxt    = S_MEM;
                            mem_rd_nxt   = 1'b1;
                            mem_addr_nxt = dec_addr;
                        end
                        OP_STORE: begin
                            state_nxt     = S_STORE;
                            mem_wr_nxt    = 1'b1;
                            mem_addr_nxt  = dec_addr;
                            rf_rd_sel_nxt = dec_reg;
                        end
                        default: begin
                            state_nxt     = S_EXEC;
                            alu_start_nxt = 1'b1;
                            alu_op_nxt    = dec_op[0];
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (cnt == MEM_LAST) begin
                    state_nxt     = S_LD_WB;
                    rf_wr_nxt     = 1'b1;
                    rf_wr_sel_nxt = dec_reg;
                    rf_wr_src_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            // cnt is 0 in the start cycle, so alu_done is only honoured from the next cycle on
            S_EXEC: begin
                if (cnt != 8'd0 && alu_done) begin
                    state_nxt     = S_ALU_WB;
                    rf_wr_nxt     = 1'b1;
                    wb_pair_nxt   = 1'b1;
                    rf_wr_src_nxt = 1'b1;
                    rf_wr_sel_nxt = REG_PAIR_LO;
                end else if (cnt == TMO) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_LD_WB, S_STORE, S_ALU_WB: state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ir        <= '0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rf_rd_sel <= '0;
            rf_wr_sel <= '0;
            rf_wr     <= 1'b0;
            rf_wr_src <= 1'b0;
            wb_pair   <= 1'b0;
            alu_op    <= 1'b0;
            alu_start <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ir        <= ir_nxt;
            cnt       <= cnt_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_wr    <= mem_wr_nxt;
            rf_rd_sel <= rf_rd_sel_nxt;
            rf_wr_sel <= rf_wr_sel_nxt;
            rf_wr     <= rf_wr_nxt;
            rf_wr_src <= rf_wr_src_nxt;
            wb_pair   <= wb_pair_nxt;
            alu_op    <= alu_op_nxt;
            alu_start <= alu_start_nxt;
            err       <= err_nxt;
        end
    end

`ifdef CPU_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if ((state == S_LD_WB || state == S_STORE || state == S_ALU_WB)
                     && retired_cnt != '1) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer; expected timelines come from per-instruction event cycles.
module tb_cpu_sequencer;

    localparam int MEM_LAT = 1;
    localparam int TMO     = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       instr_ready, mem_rd, mem_wr, rf_wr, rf_wr_src, wb_pair;
    logic       alu_op, alu_start, alu_done = 1'b0, err, busy;
    logic [4:0] mem_addr;
    logic [1:0] rf_rd_sel, rf_wr_sel;
`ifdef CPU_SEQ_PERF_EN
    logic [15:0] retired_cnt;
    int          exp_retired = 0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.MEM_LAT(MEM_LAT), .ALU_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .rf_rd_sel   (rf_rd_sel),
        .rf_wr_sel   (rf_wr_sel),
        .rf_wr       (rf_wr),
        .rf_wr_src   (rf_wr_src),
        .wb_pair     (wb_pair),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .err         (err),
`ifdef CPU_SEQ_PERF_EN
        .retired_cnt (retired_cnt),
`endif
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // strobe vector: {ready, busy, mem_rd, mem_wr, rf_wr, wb_pair, alu_start, err}
    function automatic logic [7:0] strobes();
        return {instr_ready, busy, mem_rd, mem_wr, rf_wr, wb_pair, alu_start, err};
    endfunction

    // done_cyc: cycle (after accept) in which alu_done is raised, 0 = never
    // rst_cyc: cycle whose closing edge sees rst_n low, 0 = none
    task automatic run(input logic [8:0] ins, input int done_cyc, input int rst_cyc);
        logic [1:0] op;
        logic [1:0] rg;
        logic [4:0] ad;
        int rd_c = 0, wr_c = 0, st_c = 0, lw_c = 0, aw_c = 0, er_c = 0, e_c, r;
        int last_wait;
        logic [7:0] exp_s;
        op = ins[8:7];
        rg = ins[6:5];
        ad = ins[4:0];
        last_wait = 0;
        case (op)
            2'b00: begin rd_c = 1; lw_c = MEM_LAT + 1; e_c = MEM_LAT + 2; end
            2'b01: begin wr_c = 1; e_c = 2; end
            default: begin
                st_c = 1;
                if (done_cyc >= 2 && done_cyc <= TMO + 1) begin
                    aw_c = done_cyc + 1; e_c = done_cyc + 2; last_wait = done_cyc;
                end else begin
                    er_c = TMO + 2; e_c = TMO + 2; last_wait = TMO + 1;
                end
            end
        endcase
        r = (rst_cyc >= 1 && rst_cyc < e_c) ? rst_cyc : 0;
        if (r != 0) begin
            if (rd_c > r) rd_c = 0;
            if (wr_c > r) wr_c = 0;
            if (lw_c > r) lw_c = 0;
            if (aw_c > r) aw_c = 0;
            if (er_c > r) er_c = 0;
            e_c = r + 1;
        end

        @(negedge clk);
        check("idle_ready", {31'd0, instr_ready}, 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        alu_done    = 1'($urandom_range(0, 1));
        @(posedge clk);
        for (int k = 1; k <= e_c; k++) begin
            @(negedge clk);
            exp_s = {k == e_c, k != e_c, k == rd_c, k == wr_c, (k == lw_c) || (k == aw_c),
                     k == aw_c, k == st_c, k == er_c};
            check($sformatf("strobes_c%0d", k), {24'd0, strobes()}, {24'd0, exp_s});
            if (k == rd_c || k == wr_c) check("mem_addr", {27'd0, mem_addr}, {27'd0, ad});
            if (k == wr_c) check("rf_rd_sel", {30'd0, rf_rd_sel}, {30'd0, rg});
            if (k == lw_c) check("ld_sel_src", {29'd0, rf_wr_sel, rf_wr_src}, {29'd0, rg, 1'b0});
            if (k == aw_c) check("alu_src", {31'd0, rf_wr_src}, 32'd1);
            if (k == st_c) check("alu_op", {31'd0, alu_op}, {31'd0, op[0]});
`ifdef CPU_SEQ_PERF_EN
            if (k == e_c) begin
                if (r != 0) exp_retired = 0;
                else if (er_c == 0 && exp_retired < 16'hFFFF) exp_retired++;
                check("retired_cnt", {16'd0, retired_cnt}, exp_retired);
            end
`endif
            // busy-time noise on valid/instr/alu_done must be ignored
            instr_valid = (k < e_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            instr       = (k < e_c) ? 9'($urandom) : ins;
            if (op[1] && k >= 2 && k <= last_wait) alu_done = (k == done_cyc);
            else alu_done = 1'($urandom_range(0, 1));
            rst_n = !(k == r);
        end
        rst_n       = 1'b1;
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {24'd0, strobes()}, {24'd0, 8'b1000_0000});
        check("rst_addr_sel", {23'd0, mem_addr, rf_rd_sel, rf_wr_sel}, 32'd0);
        rst_n = 1'b1;

        run(9'b000011110, 0, 0);
        run(9'b011001010, 0, 0);
        run(9'b110000000, 4, 0);
        run(9'b100000000, 0, 0);
        run(9'b110000000, 0, 3);
        run(9'b100000000, 2, 0);
        run(9'b110000000, TMO + 1, 0);

        for (int n = 0; n < 200; n++) begin
            logic [8:0] ins;
            int dc, rc;
            ins = 9'($urandom);
            dc  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO + 3));
            rc  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
            run(ins, dc, rc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
